// File: rtl/pipelined_mlsd_decision_if.sv
// Bus bundle for pipelined_mlsd_decision: code/estimate inputs, decisions and statistics out.
// margin_out is present only when MLSD_MARGIN_OUT_EN is defined.
interface pipelined_mlsd_decision_if #(
  parameter int unsigned seqLength    = 4,
  parameter int unsigned codeBitwidth = 10,
  parameter int unsigned shiftWidth   = 4,
  parameter int unsigned numChannels  = 16,
  parameter int unsigned bufferDepth  = 3,
  parameter int unsigned nbit         = 1,
  parameter int unsigned distWidth    = 16,
  parameter int unsigned cntWidth     = 16
);
  localparam int unsigned num_hyp = 1 << nbit;

  logic                                                          in_valid;
  logic [numChannels*bufferDepth-1:0][codeBitwidth-1:0]          flat_codes;
  logic [num_hyp-1:0][numChannels-1:0][seqLength-1:0][codeBitwidth-1:0] est_seq;
  logic [numChannels-1:0][shiftWidth-1:0]                        shift_index;
  logic [distWidth-1:0]                                          margin_thresh;
  logic                                                          clr_stats;
  logic                                                          out_valid;
  logic [numChannels-1:0][nbit-1:0]                              predict_bits;
  logic [numChannels-1:0][distWidth-1:0]                         min_dist;
  logic [cntWidth-1:0]                                           lowconf_count;
`ifdef MLSD_MARGIN_OUT_EN
  logic [numChannels-1:0][distWidth-1:0]                         margin_out;
`endif

  modport master (
    output in_valid, flat_codes, est_seq, shift_index, margin_thresh, clr_stats,
    input  out_valid, predict_bits, min_dist,
`ifdef MLSD_MARGIN_OUT_EN
           margin_out,
`endif
           lowconf_count
  );

  modport slave (
    input  in_valid, flat_codes, est_seq, shift_index, margin_thresh, clr_stats,
    output out_valid, predict_bits, min_dist,
`ifdef MLSD_MARGIN_OUT_EN
           margin_out,
`endif
           lowconf_count
  );
endinterface

// File: rtl/pipelined_mlsd_decision.sv
// Three-stage MLSD slicer: error, shifted squared distance, argmin with margin and low-confidence tally.
// Optional MLSD_MARGIN_OUT_EN exposes the per-channel decision margin as a registered output.
module pipelined_mlsd_decision #(
  parameter int unsigned seqLength    = 4,
  parameter int unsigned codeBitwidth = 10,
  parameter int unsigned shiftWidth   = 4,
  parameter int unsigned numChannels  = 16,
  parameter int unsigned bufferDepth  = 3,
  parameter int unsigned centerBuffer = 1,
  parameter int unsigned nbit         = 1,
  parameter int unsigned cbit         = 1,
  parameter int unsigned distWidth    = 16,
  parameter int unsigned cntWidth     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_mlsd_decision_if.slave bus
);
  localparam int unsigned num_hyp   = 1 << nbit;
  localparam int unsigned err_w     = codeBitwidth + 1;
  localparam int unsigned sq_w      = 2 * err_w;
  localparam int unsigned sum_w     = sq_w + $clog2(seqLength) + 1;
  localparam int unsigned num_codes = numChannels * bufferDepth;
  localparam int unsigned win_base  = centerBuffer * numChannels + cbit;
  localparam int unsigned top_idx   = win_base + (numChannels - 1) + (seqLength - 1);
  localparam int unsigned ch_cnt_w  = $clog2(numChannels + 1);
  localparam int unsigned add_w     = ((cntWidth > ch_cnt_w) ? cntWidth : ch_cnt_w) + 1;

  localparam logic [distWidth-1:0] dist_max = '1;
  localparam logic [cntWidth-1:0]  cnt_max  = '1;

  if (top_idx > num_codes - 1) begin : g_window_chk
    $error("pipelined_mlsd_decision: compare window runs past flat_codes");
  end
  if (nbit < 1) begin : g_nbit_chk
    $error("pipelined_mlsd_decision: nbit must be at least 1");
  end

  // Stage 1: per-tap error between measured window and each hypothesis
  logic                    v1;
  logic signed [err_w-1:0] err_d [num_hyp][numChannels][seqLength];
  logic signed [err_w-1:0] err_q [num_hyp][numChannels][seqLength];
  logic [shiftWidth-1:0]   shift_q [numChannels];

  always_comb begin
    for (int h = 0; h < int'(num_hyp); h++) begin
      for (int c = 0; c < int'(numChannels); c++) begin
        for (int k = 0; k < int'(seqLength); k++) begin
          err_d[h][c][k] = err_w'($signed(bus.flat_codes[int'(win_base) + c + k]))
                         - err_w'($signed(bus.est_seq[h][c][k]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int h = 0; h < int'(num_hyp); h++)
        for (int c = 0; c < int'(numChannels); c++)
          for (int k = 0; k < int'(seqLength); k++)
            err_q[h][c][k] <= '0;
      for (int c = 0; c < int'(numChannels); c++)
        shift_q[c] <= '0;
    end else begin
      v1    <= bus.in_valid;
      err_q <= err_d;
      for (int c = 0; c < int'(numChannels); c++)
        shift_q[c] <= bus.shift_index[c];
    end
  end

  // Stage 2: sum of per-tap shifted squares, saturated to the distance width
  logic                   v2;
  logic signed [sq_w-1:0] sq_ext;
  logic signed [sq_w-1:0] sq_prod;
  logic [sq_w-1:0]        sq_term;
  logic [sum_w-1:0]       dist_acc;
  logic [distWidth-1:0]   dist_d [num_hyp][numChannels];
  logic [distWidth-1:0]   dist_q [num_hyp][numChannels];

  always_comb begin
    sq_ext   = '0;
    sq_prod  = '0;
    sq_term  = '0;
    dist_acc = '0;
    for (int h = 0; h < int'(num_hyp); h++) begin
      for (int c = 0; c < int'(numChannels); c++) begin
        dist_acc = '0;
        for (int k = 0; k < int'(seqLength); k++) begin
          sq_ext   = sq_w'(err_q[h][c][k]);
          sq_prod  = sq_ext * sq_ext;
          sq_term  = $unsigned(sq_prod) >> shift_q[c];
          dist_acc = dist_acc + sum_w'(sq_term);
        end
        dist_d[h][c] = (dist_acc > sum_w'(dist_max)) ? dist_max : distWidth'(dist_acc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      for (int h = 0; h < int'(num_hyp); h++)
        for (int c = 0; c < int'(numChannels); c++)
          dist_q[h][c] <= '0;
    end else begin
      v2     <= v1;
      dist_q <= dist_d;
    end
  end

  // Stage 3: argmin (lowest index wins ties) and smallest-to-runner-up margin
  logic [nbit-1:0]      best_i [numChannels];
  logic [distWidth-1:0] best_d [numChannels];
  logic [distWidth-1:0] margin [numChannels];
  logic [distWidth-1:0] second_d;
  logic [ch_cnt_w-1:0]  low_n;

  always_comb begin
    second_d = '0;
    low_n    = '0;
    for (int c = 0; c < int'(numChannels); c++) begin
      best_d[c] = dist_q[0][c];
      best_i[c] = '0;
      second_d  = dist_max;
      for (int h = 1; h < int'(num_hyp); h++) begin
        if (dist_q[h][c] < best_d[c]) begin
          second_d  = best_d[c];
          best_d[c] = dist_q[h][c];
          best_i[c] = nbit'(h);
        end else if (dist_q[h][c] < second_d) begin
          second_d = dist_q[h][c];
        end
      end
      margin[c] = second_d - best_d[c];
      if (margin[c] < bus.margin_thresh) low_n = low_n + ch_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.predict_bits <= '0;
      bus.min_dist     <= '0;
`ifdef MLSD_MARGIN_OUT_EN
      bus.margin_out   <= '0;
`endif
    end else begin
      bus.out_valid <= v2;
      if (v2) begin
        for (int c = 0; c < int'(numChannels); c++) begin
          bus.predict_bits[c] <= best_i[c];
          bus.min_dist[c]     <= best_d[c];
`ifdef MLSD_MARGIN_OUT_EN
          bus.margin_out[c]   <= margin[c];
`endif
        end
      end
    end
  end

  // Low-confidence tally: saturating add, clear takes priority
  logic [add_w-1:0]    cnt_sum;
  logic [cntWidth-1:0] cnt_next;

  always_comb begin
    cnt_sum  = add_w'(bus.lowconf_count) + add_w'(low_n);
    cnt_next = (cnt_sum > add_w'(cnt_max)) ? cnt_max : cntWidth'(cnt_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lowconf_count <= '0;
    end else if (bus.clr_stats) begin
      bus.lowconf_count <= '0;
    end else if (v2) begin
      bus.lowconf_count <= cnt_next;
    end
  end

endmodule
